// File: rtl/irq_controller.sv
// External interrupt controller: edge-detects NSRC lines into pending bits, masks them,
// picks the lowest-index active source and holds ExtIRQ until the core acknowledges.
module irq_controller #(
    parameter int             N         = 64,
    parameter int             NSRC      = 4,
    parameter logic [N-1:0]   MASK_ADDR = 'h400,
    parameter logic [N-1:0]   CLR_ADDR  = 'h408,
    localparam int            IDW       = $clog2(NSRC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   irq_src,
    input  logic [N-1:0]      DM_addr,
    input  logic [N-1:0]      DM_writeData,
    input  logic              DM_writeEnable,
    input  logic              ExtIAck,
    output logic              ExtIRQ,
    output logic [IDW-1:0]    irq_id,
    output logic [NSRC-1:0]   pending,
    output logic [NSRC-1:0]   overrun
);

    typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

    state_t            state_q, state_d;
    logic              ext_irq_q, ext_irq_d;
    logic [IDW-1:0]    irq_id_q, irq_id_d;
    logic [NSRC-1:0]   src_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   overrun_q, overrun_d;
    logic [NSRC-1:0]   mask_q, mask_d;

    logic [NSRC-1:0]   rise, active, ack_clr, clr_pend, clr_ovr, clr;
    logic              mask_wr, clr_wr;
    logic [IDW-1:0]    winner;

    always_comb begin
        rise     = irq_src & ~src_q;
        mask_wr  = DM_writeEnable && (DM_addr == MASK_ADDR);
        clr_wr   = DM_writeEnable && (DM_addr == CLR_ADDR);
        clr_pend = clr_wr ? DM_writeData[NSRC-1:0]      : '0;
        clr_ovr  = clr_wr ? DM_writeData[2*NSRC-1:NSRC] : '0;

        ack_clr = '0;
        if (state_q == REQ && ExtIAck)
            ack_clr[irq_id_q] = 1'b1;
        clr = clr_pend | ack_clr;

        // A new edge always wins over any clear landing in the same cycle.
        pending_d = rise | (pending_q & ~clr);
        overrun_d = (rise & pending_q & ~clr) | (overrun_q & ~clr_ovr);
        mask_d    = mask_wr ? DM_writeData[NSRC-1:0] : mask_q;

        active = pending_q & mask_q;
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i])
                winner = IDW'(i);

        state_d   = state_q;
        ext_irq_d = ext_irq_q;
        irq_id_d  = irq_id_q;
        case (state_q)
            IDLE: if (active != '0) begin
                irq_id_d  = winner;
                ext_irq_d = 1'b1;
                state_d   = REQ;
            end
            // Once raised, the request is held until acknowledged, whatever mask/CLR do.
            REQ: if (ExtIAck) begin
                ext_irq_d = 1'b0;
                state_d   = ACKD;
            end
            ACKD: if (!ExtIAck)
                state_d = IDLE;
            default: begin
                state_d   = IDLE;
                ext_irq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        src_q <= irq_src;
        if (reset) begin
            state_q   <= IDLE;
            ext_irq_q <= 1'b0;
            irq_id_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '1;
        end else begin
            state_q   <= state_d;
            ext_irq_q <= ext_irq_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
        end
    end

    assign ExtIRQ  = ext_irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a request-level model queues expected outputs per
// cycle and expected request ids; a monitor pops them on the falling edge and compares.
module tb_irq_controller;

    localparam int          N         = 64;
    localparam int          NSRC      = 4;
    localparam logic [63:0] MASK_ADDR = 64'h400;
    localparam logic [63:0] CLR_ADDR  = 64'h408;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic [N-1:0]    DM_addr, DM_writeData;
    logic            DM_writeEnable, ExtIAck;
    logic            ExtIRQ;
    logic [1:0]      irq_id;
    logic [NSRC-1:0] pending, overrun;

    irq_controller #(.N(N), .NSRC(NSRC), .MASK_ADDR(MASK_ADDR), .CLR_ADDR(CLR_ADDR)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .DM_addr(DM_addr),
        .DM_writeData(DM_writeData), .DM_writeEnable(DM_writeEnable), .ExtIAck(ExtIAck),
        .ExtIRQ(ExtIRQ), .irq_id(irq_id), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            irq;
        logic [1:0]      id;
        logic [NSRC-1:0] pend;
        logic [NSRC-1:0] ovr;
    } exp_t;

    exp_t       state_q[$];
    logic [1:0] req_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Request-level model: a request is either "raised" (waiting for ack) or "draining"
    // (ack seen, waiting for it to drop); otherwise the controller is free to raise one.
    logic [NSRC-1:0] m_pend, m_ovr, m_mask, m_prev;
    logic            m_raised, m_draining;
    logic [1:0]      m_id;

    function automatic logic [1:0] lowest_set(input logic [NSRC-1:0] v);
        logic [NSRC-1:0] iso;
        iso = v & (~v + 1'b1);
        return 2'($clog2(iso));
    endfunction

    task automatic model_step();
        logic [NSRC-1:0] rise, clr, ovr_clr, act;
        exp_t e;
        if (reset) begin
            m_pend = '0; m_ovr = '0; m_mask = '1;
            m_raised = 1'b0; m_draining = 1'b0; m_id = '0;
        end else begin
            rise    = irq_src & ~m_prev;
            clr     = '0;
            ovr_clr = '0;
            if (DM_writeEnable && DM_addr == CLR_ADDR) begin
                clr     = DM_writeData[NSRC-1:0];
                ovr_clr = DM_writeData[2*NSRC-1:NSRC];
            end
            if (m_raised && ExtIAck) clr = clr | (NSRC'(1) << m_id);
            act = m_pend & m_mask;
            if (m_raised) begin
                if (ExtIAck) begin m_raised = 1'b0; m_draining = 1'b1; end
            end else if (m_draining) begin
                if (!ExtIAck) m_draining = 1'b0;
            end else if (act != 0) begin
                m_raised = 1'b1;
                m_id     = lowest_set(act);
                req_q.push_back(m_id);
            end
            m_ovr  = (rise & m_pend & ~clr) | (m_ovr & ~ovr_clr);
            m_pend = rise | (m_pend & ~clr);
            if (DM_writeEnable && DM_addr == MASK_ADDR) m_mask = DM_writeData[NSRC-1:0];
        end
        m_prev = irq_src;
        e.irq = m_raised; e.id = m_id; e.pend = m_pend; e.ovr = m_ovr;
        state_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic dm_write(input logic [63:0] a, input logic [63:0] d);
        DM_writeEnable = 1'b1; DM_addr = a; DM_writeData = d;
        tick();
        DM_writeEnable = 1'b0; DM_addr = '0; DM_writeData = '0;
    endtask

    task automatic ack_pulse();
        ExtIAck = 1'b1; tick();
        ExtIAck = 1'b0; tick();
    endtask

    // Monitor: every cycle's visible state, plus the id presented on each ExtIRQ rise.
    logic prev_irq = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] want_id;
        if (state_q.size() > 0) begin
            e = state_q.pop_front();
            vectors++;
            if (ExtIRQ !== e.irq || irq_id !== e.id || pending !== e.pend || overrun !== e.ovr) begin
                miscompares++;
                $display("FAIL state t=%0t got irq=%b id=%0d pend=%b ovr=%b want irq=%b id=%0d pend=%b ovr=%b",
                         $time, ExtIRQ, irq_id, pending, overrun, e.irq, e.id, e.pend, e.ovr);
            end
        end
        if (ExtIRQ === 1'b1 && prev_irq === 1'b0) begin
            vectors++;
            if (req_q.size() == 0) begin
                miscompares++;
                $display("FAIL request t=%0t got unexpected request id=%0d want none", $time, irq_id);
            end else begin
                want_id = req_q.pop_front();
                if (irq_id !== want_id) begin
                    miscompares++;
                    $display("FAIL request_id t=%0t got %0d want %0d", $time, irq_id, want_id);
                end
            end
        end
        prev_irq <= ExtIRQ;
    end

    initial begin
        reset = 1'b1; irq_src = '0; DM_addr = '0; DM_writeData = '0;
        DM_writeEnable = 1'b0; ExtIAck = 1'b0;
        m_prev = '0;
        tick(2);
        reset = 1'b0;
        tick();

        // Single source, long hold before ack.
        irq_src = 4'b0100; tick();
        irq_src = 4'b0000; tick(6);
        ack_pulse(); tick(2);

        // Two simultaneous sources: lowest index first, gap between requests.
        irq_src = 4'b1010; tick();
        irq_src = 4'b0000; tick(3);
        ack_pulse(); tick(3);
        ack_pulse(); tick(2);

        // Masked pending stays latched, fires on unmask.
        dm_write(MASK_ADDR, 64'h0);
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick(4);
        dm_write(MASK_ADDR, 64'hF); tick(3);
        ack_pulse(); tick(2);

        // Overrun, CLR of pending+overrun, and set-wins on a same-cycle edge.
        irq_src = 4'b0010; tick();
        irq_src = 4'b0000; tick();
        irq_src = 4'b0010; tick();
        irq_src = 4'b0000; tick(2);
        dm_write(CLR_ADDR, 64'h22); tick(2);
        ack_pulse(); tick(2);
        irq_src = 4'b0010; dm_write(CLR_ADDR, 64'h22);
        irq_src = 4'b0000; tick(3);
        ack_pulse(); tick(3);

        // Line high through reset release is not an edge.
        irq_src = 4'b0001; reset = 1'b1; tick(2);
        reset = 1'b0; tick(4);
        irq_src = 4'b0000; tick();
        irq_src = 4'b0001; tick(4);
        ack_pulse();
        irq_src = 4'b0000; tick(2);

        // Reset during a request on source 3, then a non-decoded write leaves mask alone.
        dm_write(CLR_ADDR, 64'hFF);
        irq_src = 4'b1000; tick();
        irq_src = 4'b0000; tick(3);
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        dm_write(64'h410, 64'h0);
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick(4);
        ack_pulse(); tick(2);

        for (int c = 0; c < 3000; c++) begin
            irq_src = irq_src ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 3) == 0) ExtIAck = ~ExtIAck;
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) begin
                DM_writeEnable = 1'b1;
                case ($urandom_range(0, 3))
                    0: DM_addr = MASK_ADDR;
                    1: DM_addr = CLR_ADDR;
                    2: DM_addr = 64'h410;
                    default: DM_addr = {$urandom, $urandom};
                endcase
                DM_writeData = {$urandom, $urandom};
                if (DM_addr == MASK_ADDR && $urandom_range(0, 1) == 0) DM_writeData[3:0] = 4'hF;
            end else begin
                DM_writeEnable = 1'b0;
            end
            tick();
        end
        reset = 1'b0; DM_writeEnable = 1'b0; ExtIAck = 1'b0; irq_src = '0;
        tick(3);
        @(negedge clk); #1;

        vectors++;
        if (req_q.size() != 0) begin
            miscompares++;
            $display("FAIL request_drain got %0d requests never raised want 0", req_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
